// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_if
// Description : MEM-to-WB pipeline bundle: control, MEM entry, WB outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        m_valid;
  logic        m_regwrite;
  logic [1:0]  m_wbsel;
  logic [2:0]  m_ldtype;
  logic [4:0]  m_rd;
  logic [31:0] m_alu_out;
  logic [31:0] m_rdata;
  logic [31:0] m_pc8;
  logic        w_we;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic        w_valid;
  logic        misalign_err;
  logic [31:0] retire_cnt;

  modport master (
    output stall, flush, m_valid, m_regwrite, m_wbsel, m_ldtype, m_rd,
           m_alu_out, m_rdata, m_pc8,
    input  w_we, w_addr, w_data, w_valid, misalign_err, retire_cnt
  );

  modport slave (
    input  stall, flush, m_valid, m_regwrite, m_wbsel, m_ldtype, m_rd,
           m_alu_out, m_rdata, m_pc8,
    output w_we, w_addr, w_data, w_valid, misalign_err, retire_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline register with load extraction, misalignment
//               detection and a retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage (
  input  logic            clk,
  input  logic            rst,
  mem_wb_stage_if.slave   bus
);

  localparam logic [2:0] c_LD_LB  = 3'b001;
  localparam logic [2:0] c_LD_LBU = 3'b010;
  localparam logic [2:0] c_LD_LH  = 3'b011;
  localparam logic [2:0] c_LD_LHU = 3'b100;

  localparam logic [1:0] c_WB_LOAD = 2'b01;
  localparam logic [1:0] c_WB_LINK = 2'b10;

  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_is_half;
  logic        w_is_word;
  logic [31:0] w_load_data;
  logic        w_misalign;
  logic [31:0] w_wb_data;
  logic        w_we_next;
  logic [4:0]  w_addr_next;

  logic        r_valid;
  logic        r_we;
  logic [4:0]  r_addr;
  logic [31:0] r_data;
  logic        r_misalign;
  logic [31:0] r_retire_cnt;

  always_comb begin
    w_off = bus.m_alu_out[1:0];
    case (w_off)
      2'd0:    w_byte = bus.m_rdata[7:0];
      2'd1:    w_byte = bus.m_rdata[15:8];
      2'd2:    w_byte = bus.m_rdata[23:16];
      default: w_byte = bus.m_rdata[31:24];
    endcase
    w_half    = w_off[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    w_is_half = (bus.m_ldtype == c_LD_LH) || (bus.m_ldtype == c_LD_LHU);
    // Undefined load types fall back to a full-word load
    w_is_word = !w_is_half && (bus.m_ldtype != c_LD_LB) && (bus.m_ldtype != c_LD_LBU);

    case (bus.m_ldtype)
      c_LD_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
      c_LD_LBU: w_load_data = {24'd0, w_byte};
      c_LD_LH:  w_load_data = {{16{w_half[15]}}, w_half};
      c_LD_LHU: w_load_data = {16'd0, w_half};
      default:  w_load_data = bus.m_rdata;
    endcase

    w_misalign = (bus.m_wbsel == c_WB_LOAD) &&
                 ((w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00)));

    case (bus.m_wbsel)
      c_WB_LOAD: w_wb_data = w_load_data;
      c_WB_LINK: w_wb_data = bus.m_pc8;
      default:   w_wb_data = bus.m_alu_out;
    endcase

    w_we_next   = bus.m_valid && bus.m_regwrite && (bus.m_rd != 5'd0) && !w_misalign;
    w_addr_next = w_we_next ? bus.m_rd : 5'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid      <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= 5'd0;
      r_data       <= 32'd0;
      r_misalign   <= 1'b0;
      r_retire_cnt <= 32'd0;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 5'd0;
      r_data     <= 32'd0;
      r_misalign <= 1'b0;
    end else if (bus.stall) begin
      r_misalign <= 1'b0;
    end else begin
      r_valid    <= bus.m_valid;
      r_we       <= w_we_next;
      r_addr     <= w_addr_next;
      r_data     <= w_wb_data;
      r_misalign <= bus.m_valid && w_misalign;
      if (bus.m_valid) begin
        r_retire_cnt <= r_retire_cnt + 32'd1;
      end
    end
  end

  assign bus.w_valid      = r_valid;
  assign bus.w_we         = r_we;
  assign bus.w_addr       = r_addr;
  assign bus.w_data       = r_data;
  assign bus.misalign_err = r_misalign;
  assign bus.retire_cnt   = r_retire_cnt;

endmodule
`default_nettype wire
